// File: rtl/branch_predictor.sv
// branch_predictor
//   Dynamic branch predictor for the 5-stage MIPS pipeline. This module holds
//   a table of 2-bit saturating counters, indexed by pc[BHT_INDEX_BITS+1:2],
//   with no tags. It has three jobs:
//     - In ID it predicts combinationally from the registered table.
//     - In EX it resolves the branch and raises the flush/redirect.
//     - On each clock edge it trains the counter of the EX branch and
//       updates the statistics.
//
//   Ports:
//     clk, reset         clock; synchronous active-high reset
//     id_pc              PC of the instruction in ID
//     id_branch          ID instruction is a conditional branch
//     id_branch_target   branch target computed in ID
//     id_prediction      predicted taken (to the ID/EX latch)
//     id_target          target forwarded to the ID/EX latch
//     ex_branch          EX holds a valid branch
//     ex_pc              PC of the EX branch
//     ex_taken           actual branch outcome
//     ex_prediction      prediction carried through ID/EX
//     ex_target          target carried through ID/EX
//     mispredict         flush request for IF/ID and ID/EX
//     redirect_pc        correct next PC while mispredict=1, else 0
//     branch_count       resolved branches since reset
//     mispredict_count   mispredictions since reset
module branch_predictor #(
    parameter int unsigned BHT_INDEX_BITS = 6,
    parameter logic [1:0]  COUNTER_RESET  = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_pc,
    input  logic        id_branch,
    input  logic [31:0] id_branch_target,
    output logic        id_prediction,
    output logic [31:0] id_target,
    input  logic        ex_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic        ex_prediction,
    input  logic [31:0] ex_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int unsigned ENTRIES = 1 << BHT_INDEX_BITS;

    logic [1:0] bht [ENTRIES];

    logic [BHT_INDEX_BITS-1:0] id_idx;
    logic [BHT_INDEX_BITS-1:0] ex_idx;

    assign id_idx = id_pc[BHT_INDEX_BITS+1:2];
    assign ex_idx = ex_pc[BHT_INDEX_BITS+1:2];

    // PC bits outside the index never reach the table (no tags).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{id_pc[31:BHT_INDEX_BITS+2], id_pc[1:0],
                              ex_pc[31:BHT_INDEX_BITS+2], ex_pc[1:0]};

    // Prediction reads the registered table. An EX update to the same index
    // in this cycle is not bypassed.
    always_comb begin
        id_prediction = id_branch & bht[id_idx][1];
        // The target is forwarded for every branch so that a not-taken
        // prediction that resolves taken still has its target in the latch.
        id_target     = id_branch ? id_branch_target : '0;
    end

    always_comb begin
        mispredict  = ex_branch & (ex_taken != ex_prediction);
        redirect_pc = '0;
        if (mispredict) begin
            redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                bht[i] <= COUNTER_RESET;
            end
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (ex_branch) begin
            if (ex_taken) begin
                if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'd1;
            end else begin
                if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
            end
            branch_count <= branch_count + 32'd1;
            if (mispredict) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//   Self-checking bench for branch_predictor. It has three phases:
//     - a table of resolve vectors applied while reset is held;
//   - hand-written training, aliasing and same-cycle sequences;
//     - randomized traffic compared against a counter-array reference model.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] id_pc;
    logic        id_branch;
    logic [31:0] id_branch_target;
    logic        id_prediction;
    logic [31:0] id_target;
    logic        ex_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic        ex_prediction;
    logic [31:0] ex_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int compared = 0;
    int mismatched = 0;

    branch_predictor #(.BHT_INDEX_BITS(6), .COUNTER_RESET(2'b01)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_pc            (id_pc),
        .id_branch        (id_branch),
        .id_branch_target (id_branch_target),
        .id_prediction    (id_prediction),
        .id_target        (id_target),
        .ex_branch        (ex_branch),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_prediction    (ex_prediction),
        .ex_target        (ex_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic        taken;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        exp_mis;
        logic [31:0] exp_redir;
    } resolve_vec_t;

    // Reference model: plain integer counters 0..3 and counts.
    int          m_ctr [64];
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_ctr[i] = 1;
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic model_edge();
        int idx;
        if (reset) begin
            model_reset();
        end else if (ex_branch) begin
            idx = int'((ex_pc >> 2) % 64);
            if (ex_taken) m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
            else          m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
            m_bc = m_bc + 1;
            if (ex_taken != ex_prediction) m_mc = m_mc + 1;
        end
    endtask

    task automatic model_check();
        int          idx;
        logic        e_pred;
        logic        e_mis;
        logic [31:0] e_redir;
        idx     = int'((id_pc >> 2) % 64);
        e_pred  = id_branch && (m_ctr[idx] >= 2);
        e_mis   = ex_branch && (ex_taken != ex_prediction);
        e_redir = !e_mis ? 32'h0 : (ex_taken ? ex_target : ex_pc + 32'd4);
        check("rnd_id_prediction", {31'b0, id_prediction}, {31'b0, e_pred});
        check("rnd_id_target", id_target, id_branch ? id_branch_target : 32'h0);
        check("rnd_mispredict", {31'b0, mispredict}, {31'b0, e_mis});
        check("rnd_redirect_pc", redirect_pc, e_redir);
        check("rnd_branch_count", branch_count, m_bc);
        check("rnd_mispredict_count", mispredict_count, m_mc);
    endtask

    task automatic set_ex(input logic br, input logic [31:0] pc, input logic taken,
                          input logic pred, input logic [31:0] tgt);
        ex_branch = br; ex_pc = pc; ex_taken = taken; ex_prediction = pred; ex_target = tgt;
    endtask

    resolve_vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0080, 1'b1, 32'h0000_0080};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 1'b1, 32'h0000_0044};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0080, 1'b0, 32'h0000_0000};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0080, 1'b0, 32'h0000_0000};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_2000, 1'b1, 32'h0000_2000};

        reset = 1'b1;
        id_pc = 32'h40; id_branch = 1'b0; id_branch_target = 32'h0;
        set_ex(1'b1, 32'h40, 1'b1, 1'b0, 32'h80);   // reset must beat this training
        tick();
        tick();

        // Resolve logic is purely combinational; held reset keeps state frozen.
        foreach (vecs[i]) begin
            set_ex(vecs[i].br, vecs[i].pc, vecs[i].taken, vecs[i].pred, vecs[i].tgt);
            #1;
            check("tbl_mispredict", {31'b0, mispredict}, {31'b0, vecs[i].exp_mis});
            check("tbl_redirect_pc", redirect_pc, vecs[i].exp_redir);
            tick();
        end

        // Release reset: counters 01, counts 0.
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        id_branch = 1'b1; id_pc = 32'h40; id_branch_target = 32'h80;
        #1;
        check("rst_branch_count", branch_count, 32'h0);
        check("rst_mispredict_count", mispredict_count, 32'h0);
        check("rst_id_prediction", {31'b0, id_prediction}, 32'h0);
        check("rst_id_target", id_target, 32'h80);
        tick();

        // Taken resolve at 0x40 while ID reads the same index: ID sees old 01.
        set_ex(1'b1, 32'h40, 1'b1, 1'b0, 32'h80);
        #1;
        check("seq1_mispredict", {31'b0, mispredict}, 32'h1);
        check("seq1_redirect", redirect_pc, 32'h80);
        check("seq1_same_cycle_pred", {31'b0, id_prediction}, 32'h0);
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("seq1_after_pred", {31'b0, id_prediction}, 32'h1);
        check("seq1_bc", branch_count, 32'd1);
        check("seq1_mc", mispredict_count, 32'd1);

        // Two more taken, correctly predicted: 10 -> 11 -> 11 (saturate).
        for (int k = 0; k < 2; k++) begin
            set_ex(1'b1, 32'h40, 1'b1, 1'b1, 32'h0);
            #1;
            check("seq2_no_mispredict", {31'b0, mispredict}, 32'h0);
            tick();
        end
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        id_pc = 32'h140;
        #1;
        check("alias_pred_0x140", {31'b0, id_prediction}, 32'h1);
        id_pc = 32'h44;
        #1;
        check("other_idx_pred_0x44", {31'b0, id_prediction}, 32'h0);
        id_pc = 32'h40; id_branch = 1'b0;
        #1;
        check("nonbranch_pred", {31'b0, id_prediction}, 32'h0);
        check("nonbranch_target", id_target, 32'h0);
        id_branch = 1'b1;
        check("seq2_bc", branch_count, 32'd3);

        // Not-taken with predicted taken: 11 -> 10, still predicts taken.
        set_ex(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
        #1;
        check("seq3_mispredict", {31'b0, mispredict}, 32'h1);
        check("seq3_redirect", redirect_pc, 32'h44);
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("seq3_pred_after", {31'b0, id_prediction}, 32'h1);
        check("seq3_mc", mispredict_count, 32'd2);
        // Second not-taken: 10 -> 01, predicts not-taken.
        set_ex(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("seq4_pred_after", {31'b0, id_prediction}, 32'h0);
        check("seq4_bc", branch_count, 32'd5);
        check("seq4_mc", mispredict_count, 32'd3);

        // Reset held alongside a taken EX branch.
        reset = 1'b1;
        set_ex(1'b1, 32'h40, 1'b1, 1'b0, 32'h80);
        tick();
        tick();
        reset = 1'b0;
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("rst2_bc", branch_count, 32'h0);
        check("rst2_mc", mispredict_count, 32'h0);
        check("rst2_pred", {31'b0, id_prediction}, 32'h0);

        // Randomized phase against the reference model (state is fresh from reset).
        model_reset();
        for (int n = 0; n < 600; n++) begin
            logic [31:0] r;
            reset     = ($urandom_range(0, 59) == 0);
            id_branch = $urandom_range(0, 3) != 0;
            r = $urandom;
            id_pc = (r & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | (r & 32'h3);
            id_branch_target = $urandom;
            r = $urandom;
            ex_branch = $urandom_range(0, 3) != 0;
            ex_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                  : ((r & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2));
            ex_taken = $urandom_range(0, 2) != 0;
            ex_prediction = $urandom_range(0, 1) == 1;
            ex_target = ex_prediction ? 32'h0 : $urandom;
            #1;
            model_check();
            model_edge();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
